// File: rtl/exec_commit_stage.sv
// exec_commit_stage
// Registered commit stage sitting directly after the combinational ALU.
// Decodes the ARM condition field against the architectural NZCV flags and
// latches the ALU result into the execute/writeback register. It also owns
// the CPSR flag register and counts committed instructions.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid        an instruction is presented on the ALU outputs
//   cond            ARM condition field of the presented instruction
//   rd              destination register index
//   alu_dataout     ALU result
//   alu_writeback   ALU opcode produces a register result
//   alu_flagsout    ALU flags {N,Z,C,V}
//   flags_we        instruction updates the flags
//   stall           hold all state; the presented instruction is not consumed
//   flush           kill the presented instruction and empty the output register
//   flags           architectural NZCV, fed back to the ALU
//   cond_pass       combinational condition result under the current flags
//   out_valid       output register holds a committed instruction
//   out_rd/out_data registered destination index and result
//   out_we          registered register-file write enable
//   out_pc_write    registered; committed write targets r15
//   retired_count   committed-instruction counter (wraps)
module exec_commit_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        cond,
  input  logic [3:0]        rd,
  input  logic [DATA_W-1:0] alu_dataout,
  input  logic              alu_writeback,
  input  logic [3:0]        alu_flagsout,
  input  logic              flags_we,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        flags,
  output logic              cond_pass,
  output logic              out_valid,
  output logic [3:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic              out_pc_write,
  output logic [CNT_W-1:0]  retired_count
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic commit;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'd0:    cond_pass = flag_z;
      4'd1:    cond_pass = ~flag_z;
      4'd2:    cond_pass = flag_c;
      4'd3:    cond_pass = ~flag_c;
      4'd4:    cond_pass = flag_n;
      4'd5:    cond_pass = ~flag_n;
      4'd6:    cond_pass = flag_v;
      4'd7:    cond_pass = ~flag_v;
      4'd8:    cond_pass = flag_c & ~flag_z;
      4'd9:    cond_pass = ~flag_c | flag_z;
      4'd10:   cond_pass = (flag_n == flag_v);
      4'd11:   cond_pass = (flag_n != flag_v);
      4'd12:   cond_pass = ~flag_z & (flag_n == flag_v);
      4'd13:   cond_pass = flag_z | (flag_n != flag_v);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0; // NV never executes
    endcase
  end

  assign commit = in_valid & cond_pass & ~stall & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags         <= 4'b0000;
      out_valid     <= 1'b0;
      out_rd        <= 4'd0;
      out_data      <= '0;
      out_we        <= 1'b0;
      out_pc_write  <= 1'b0;
      retired_count <= '0;
    end else if (flush) begin
      // Flush outranks stall; out_rd/out_data are left stale.
      out_valid    <= 1'b0;
      out_we       <= 1'b0;
      out_pc_write <= 1'b0;
    end else if (!stall) begin
      out_valid    <= commit;
      out_we       <= commit & alu_writeback;
      out_pc_write <= commit & alu_writeback & (rd == 4'hF);
      if (in_valid) begin
        out_rd   <= rd;
        out_data <= alu_dataout;
      end
      if (commit && flags_we) begin
        flags <= alu_flagsout;
      end
      if (commit) begin
        retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_exec_commit_stage.sv
// Directed bench for exec_commit_stage with a reference model and a
// scoreboard queue of expected register contents.
module tb_exec_commit_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [3:0]        cond;
  logic [3:0]        rd;
  logic [DATA_W-1:0] alu_dataout;
  logic              alu_writeback;
  logic [3:0]        alu_flagsout;
  logic              flags_we;
  logic              stall;
  logic              flush;
  logic [3:0]        flags;
  logic              cond_pass;
  logic              out_valid;
  logic [3:0]        out_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_we;
  logic              out_pc_write;
  logic [CNT_W-1:0]  retired_count;

  exec_commit_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .rd(rd),
    .alu_dataout(alu_dataout), .alu_writeback(alu_writeback),
    .alu_flagsout(alu_flagsout), .flags_we(flags_we), .stall(stall),
    .flush(flush), .flags(flags), .cond_pass(cond_pass),
    .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
    .out_we(out_we), .out_pc_write(out_pc_write),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [3:0]        rd;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              pc;
    logic [3:0]        flags;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;  // model of the register state

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference condition decode: even codes are the base test, odd codes its
  // inverse; 14/15 are AL/NV.
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n ^ v) == 1'b0;
      3'd6: base = !z && !(n ^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic model_reset();
    m.valid = 0; m.rd = 0; m.data = 0; m.we = 0; m.pc = 0; m.flags = 0; m.cnt = 0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e.valid));
    check({tag, ".out_we"}, 32'(out_we), 32'(e.we));
    check({tag, ".out_pc_write"}, 32'(out_pc_write), 32'(e.pc));
    check({tag, ".flags"}, 32'(flags), 32'(e.flags));
    check({tag, ".retired_count"}, 32'(retired_count), 32'(e.cnt));
    if (e.valid) begin
      check({tag, ".out_rd"}, 32'(out_rd), 32'(e.rd));
      check({tag, ".out_data"}, out_data, e.data);
    end
  endtask

  // Drive one cycle (called just after a rising edge), check cond_pass,
  // push the expected register state, clock, then pop and compare.
  task automatic step(input string tag, input logic v, input logic [3:0] c,
                      input logic [3:0] r, input logic [31:0] d, input logic wb,
                      input logic [3:0] fo, input logic fwe,
                      input logic st, input logic fl);
    logic cp, com;
    exp_t got;
    in_valid = v; cond = c; rd = r; alu_dataout = d; alu_writeback = wb;
    alu_flagsout = fo; flags_we = fwe; stall = st; flush = fl;
    #1;
    cp = model_cond(m.flags, c);
    check({tag, ".cond_pass"}, 32'(cond_pass), 32'(cp));
    if (fl) begin
      m.valid = 0; m.we = 0; m.pc = 0;
    end else if (!st) begin
      com = v && cp;
      m.valid = com;
      if (v) begin m.rd = r; m.data = d; end
      m.we = com && wb;
      m.pc = com && wb && (r == 4'hF);
      if (com && fwe) m.flags = fo;
      if (com) m.cnt = m.cnt + 1'b1;
    end
    exp_q.push_back(m);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    check_outputs(tag, got);
  endtask

  task automatic idle();
    in_valid = 0; cond = 4'd14; rd = 0; alu_dataout = 0; alu_writeback = 0;
    alu_flagsout = 0; flags_we = 0; stall = 0; flush = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".flags"}, 32'(flags), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_rd"}, 32'(out_rd), 32'd0);
    check({tag, ".out_data"}, out_data, 32'd0);
    check({tag, ".out_we"}, 32'(out_we), 32'd0);
    check({tag, ".out_pc_write"}, 32'(out_pc_write), 32'd0);
    check({tag, ".retired_count"}, 32'(retired_count), 32'd0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic mid_cycle_reset(input string tag);
    idle();
    #2 rst = 1;
    #1 check_zero(tag);
    #2 rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    #12;
    check_zero("reset");
    rst = 0;
    @(posedge clk); #1;

    // Condition fail with flags 0000: EQ fails, flag write suppressed.
    step("cfail", 1, 4'd0, 4'd1, 32'hAA, 1, 4'b1000, 1, 0, 0);
    check("cfail.flags_held", 32'(flags), 32'd0);

    // CMP (AL, flags only) then EQ-conditioned write using fresh Z.
    step("cmp", 1, 4'd14, 4'd0, 32'h0, 0, 4'b0110, 1, 0, 0);
    check("cmp.flags", 32'(flags), 32'b0110);
    check("cmp.count", 32'(retired_count), 32'd1);
    step("beq", 1, 4'd0, 4'd3, 32'h55, 1, 4'b0000, 0, 0, 0);
    check("beq.out_data", out_data, 32'h55);
    check("beq.out_we", 32'(out_we), 32'd1);

    // NV never commits.
    step("nv", 1, 4'd15, 4'd4, 32'h77, 1, 4'b1111, 1, 0, 0);

    // Commit one, then stall 3 cycles presenting rd=2, then flush+stall.
    step("pre_stall", 1, 4'd14, 4'd5, 32'h1234, 1, 4'b1001, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 1, 4'd14, 4'd2, 32'h2222, 1, 4'b0001, 1, 1, 0);
    step("flush_stall", 1, 4'd14, 4'd2, 32'h2222, 1, 4'b0001, 1, 1, 1);
    check("flush_stall.out_valid", 32'(out_valid), 32'd0);
    step("replay", 1, 4'd14, 4'd2, 32'h2222, 1, 4'b0001, 1, 0, 0);
    step("flush_only", 1, 4'd14, 4'd6, 32'h3333, 1, 4'b1111, 1, 0, 1);

    // PC write for exactly one cycle.
    step("pcw", 1, 4'd14, 4'd15, 32'h8000, 1, 4'b0000, 0, 0, 0);
    check("pcw.pc_write", 32'(out_pc_write), 32'd1);
    step("pcw_after", 0, 4'd14, 4'd15, 32'h8000, 1, 4'b0000, 0, 0, 0);
    check("pcw_after.pc_write", 32'(out_pc_write), 32'd0);

    // Non-PC write with conditional GE after flags N=V=1.
    step("setnv", 1, 4'd14, 4'd7, 32'h9, 1, 4'b1001, 1, 0, 0);
    step("ge", 1, 4'd10, 4'd8, 32'hA, 1, 4'b0000, 0, 0, 0);
    step("lt", 1, 4'd11, 4'd9, 32'hB, 1, 4'b0000, 0, 0, 0);

    // Async reset with out_valid=1 and flags=1111.
    step("set_all", 1, 4'd14, 4'd1, 32'hFFFF, 1, 4'b1111, 1, 0, 0);
    check("set_all.flags", 32'(flags), 32'hF);
    check("set_all.valid", 32'(out_valid), 32'd1);
    mid_cycle_reset("async_rst");

    // Counter wrap: 17 commits from zero on a 4-bit counter reads 1.
    for (int i = 0; i < 17; i++)
      step("wrap", 1, 4'd14, 4'(i), 32'(i), 1, 4'b0000, 0, 0, 0);
    check("wrap.count_is_1", 32'(retired_count), 32'd1);

    // Full decode sweep: load each flag value, check all 16 conditions.
    for (int f = 0; f < 16; f++) begin
      step("sweep_set", 1, 4'd14, 4'd0, 32'h0, 0, 4'(f), 1, 0, 0);
      idle();
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #0.1;
        check($sformatf("sweep f=%0d c=%0d", f, c), 32'(cond_pass),
              32'(model_cond(4'(f), 4'(c))));
        if (c == 15) check("sweep.nv", 32'(cond_pass), 32'd0);
      end
      @(posedge clk); #1;
      m.valid = 0; m.we = 0; m.pc = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_commit_stage.md
Name: exec_commit_stage

Overview:
- Registered commit stage directly downstream of the combinational ALU.
- Evaluates the ARM condition field against the architectural NZCV flags and latches the ALU result into an execute/writeback pipeline register.
- Owns the CPSR flag register, whose output feeds back to the ALU flag input.
- Handles stall and flush, flags PC writes, and counts committed instructions.

Parameters:
- DATA_W, 32, datapath width of result and output registers.
- CNT_W, 32, width of the committed-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  an instruction is presented on the ALU outputs this cycle.
- cond  input  4  ARM condition field of the presented instruction.
- rd  input  4  destination register index.
- alu_dataout  input  DATA_W  ALU result.
- alu_writeback  input  1  ALU opcode produces a register result.
- alu_flagsout  input  4  ALU flags {N,Z,C,V}; bit3=N, bit2=Z, bit1=C, bit0=V.
- flags_we  input  1  instruction updates flags (S bit, or TST/TEQ/CMP/CMN).
- stall  input  1  downstream not ready; hold all state.
- flush  input  1  kill the presented instruction and empty the output register.
- flags  output  4  architectural NZCV; drives ALU flag input.
- cond_pass  output  1  combinational; condition of the presented instruction holds under current flags.
- out_valid  output  1  output register holds a committed instruction.
- out_rd  output  4  registered destination index.
- out_data  output  DATA_W  registered result.
- out_we  output  1  registered register-file write enable.
- out_pc_write  output  1  registered; committed write targets r15.
- retired_count  output  CNT_W  committed-instruction counter.

Behaviour:
- Reset, asynchronous, immediate:
  - flags=0, out_valid=0, out_rd=0, out_data=0, out_we=0, out_pc_write=0, retired_count=0.
  - Reset mid-stall or mid-flush overrides everything.
- cond_pass, decoded from current registered flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1; 15 NV 0 (never executes).
- commit = in_valid & cond_pass & !stall & !flush.
- Latency: one cycle from presentation to out_* and flags.
- Per rising edge, first matching rule applies:
  - flush=1: out_valid<=0, out_we<=0, out_pc_write<=0. flags and retired_count unchanged. out_rd/out_data may hold stale values. Flush wins over stall.
  - stall=1: every register holds its value. The presented instruction is not consumed; upstream must re-present it.
  - otherwise:
    - out_valid<=commit.
    - out_rd<=rd and out_data<=alu_dataout, loaded whenever in_valid.
    - out_we<=commit & alu_writeback.
    - out_pc_write<=commit & alu_writeback & (rd==4'hF).
    - If commit & flags_we: flags<=alu_flagsout; otherwise flags hold.
    - If commit: retired_count<=retired_count+1, wrapping modulo 2^CNT_W with no saturation.
- Condition-failed or NV instruction: becomes a bubble. out_valid=0, no flag update, no count.
- Back-to-back flag dependency: instruction N+1's cond_pass sees flags written by instruction N on the edge between them. No extra bubble.
- in_valid=0: output register becomes empty (out_valid=0, out_we=0). Flags hold.
- flags_we with alu_writeback=0 (compare ops): flags update only; out_valid=1, out_we=0.
- Outputs are registered except cond_pass.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with out_valid=1, flags=4'b1111 -> all outputs 0 immediately, before next clk edge.
- CMP then BEQ-style dependency:
  - Cycle 1: flags_we=1, alu_flagsout=4'b0110, alu_writeback=0, cond=14 -> flags=4'b0110, out_we=0, retired_count=1.
  - Cycle 2: cond=0 (EQ), rd=3, alu_dataout=32'h55 -> cond_pass=1, out_we=1, out_data=32'h55.
- Condition fail: flags=4'b0000, cond=0, flags_we=1, alu_flagsout=4'b1000 -> out_valid=0, flags stay 0000, retired_count unchanged.
- Stall and flush:
  - Stall 3 cycles with in_valid=1, rd=2 -> out_* and flags frozen.
  - Assert flush and stall together -> out_valid=0, flags unchanged.
- PC write: rd=15, alu_writeback=1, cond=14 -> out_pc_write=1 for exactly one cycle, out_we=1.
- Counter wrap: CNT_W=4, commit 17 AL instructions -> retired_count reads 4'd1.
- Full decode sweep: for each of 16 flag values x 16 cond codes, check cond_pass against the table; NV always 0.
